blend_mul_scheduler: RTL and testbench

- Sequences one shared 8x8 approximate multiplier to alpha-blend two 8-bit pixel streams.
- Output per pixel: out = hi(w1*p1) + hi(w2*p2), where hi() is product bits [15:8].
- Sits between the pixel-fetch logic and the blended-image writer.
- The multiplier is external, so any approximate multiplier variant plugs into the mul_* ports unchanged.

---
 rtl/blend_pkg.sv | 30 +++
 rtl/blend_mul_scheduler_if.sv | 26 ++
 rtl/blend_mul_scheduler.sv | 119 +++++++++++
 tb/tb_blend_mul_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/blend_pkg.sv
// Shared definitions for alpha-blend blocks: scheduler state encoding,
// weight constants, product slicing and the saturating byte adder.
package blend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        OUT  = 2'd3
    } blend_state_e;

    localparam logic [7:0] HALF_WEIGHT = 8'h80;

    // Blend weights are fixed-point fractions, so the useful part of a product is its high byte
    localparam int PROD_HI_MSB = 15;
    localparam int PROD_HI_LSB = 8;

    function automatic logic [7:0] blend_sat_add(input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic       sat);
        logic [8:0] sum9;
        sum9 = {1'b0, a} + {1'b0, b};
        if (sat && sum9[8]) begin
            return 8'hFF;
        end else begin
            return sum9[7:0];
        end
    endfunction

endpackage

// File: rtl/blend_mul_scheduler_if.sv
// Pixel-in, blended-pixel-out and shared-multiplier signals of the blend scheduler.
interface blend_mul_scheduler_if;
    logic [7:0]  w1;
    logic [7:0]  w2;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_en;
    logic [15:0] mul_y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;

    modport slave (
        input  w1, w2, in_valid, p1, p2, mul_y, out_ready,
        output in_ready, mul_a, mul_b, mul_en, out_valid, out_pix
    );

    modport master (
        output w1, w2, in_valid, p1, p2, mul_y, out_ready,
        input  in_ready, mul_a, mul_b, mul_en, out_valid, out_pix
    );
endinterface

// File: rtl/blend_mul_scheduler.sv
// Time-shares one external 8x8 multiplier to compute hi(w1*p1) + hi(w2*p2)
// per pixel pair, with frame-constant weights and a per-frame pixel counter.
module blend_mul_scheduler
    import blend_pkg::*;
#(
    parameter int NUM_PIXELS = 90000,
    parameter bit SATURATE   = 1'b0,
    parameter int CNT_W      = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    blend_mul_scheduler_if.slave  bus,
    output logic [CNT_W-1:0]      pix_cnt,
    output logic                  frame_done
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    blend_state_e     state_r;
    logic [7:0]       p2_r;
    logic [7:0]       w1_r;
    logic [7:0]       w2_r;
    logic [7:0]       part1_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [7:0]       out_pix_r;
    logic [7:0]       mul_a_r;
    logic [7:0]       mul_b_r;
    logic             mul_en_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic             frame_done_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_pix   = out_pix_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.mul_en    = mul_en_r;
    assign pix_cnt       = pix_cnt_r;
    assign frame_done    = frame_done_r;

    // Scheduler FSM; multiplier operands are loaded one state early so they are registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            p2_r         <= 8'h00;
            w1_r         <= 8'h00;
            w2_r         <= 8'h00;
            part1_r      <= 8'h00;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_pix_r    <= 8'h00;
            mul_a_r      <= 8'h00;
            mul_b_r      <= 8'h00;
            mul_en_r     <= 1'b0;
            pix_cnt_r    <= CNT_ZERO;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_ready_r && bus.in_valid) begin
                        p2_r <= bus.p2;
                        // Weights only change at a frame boundary
                        if (pix_cnt_r == CNT_ZERO) begin
                            w1_r    <= bus.w1;
                            w2_r    <= bus.w2;
                            mul_a_r <= bus.w1;
                        end else begin
                            mul_a_r <= w1_r;
                        end
                        mul_b_r    <= bus.p1;
                        mul_en_r   <= 1'b1;
                        in_ready_r <= 1'b0;
                        state_r    <= MUL1;
                    end
                end
                MUL1: begin
                    part1_r <= bus.mul_y[PROD_HI_MSB:PROD_HI_LSB];
                    mul_a_r <= w2_r;
                    mul_b_r <= p2_r;
                    state_r <= MUL2;
                end
                MUL2: begin
                    out_pix_r   <= blend_sat_add(part1_r, bus.mul_y[PROD_HI_MSB:PROD_HI_LSB], SATURATE);
                    out_valid_r <= 1'b1;
                    mul_a_r     <= 8'h00;
                    mul_b_r     <= 8'h00;
                    mul_en_r    <= 1'b0;
                    state_r     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                        if (pix_cnt_r == LAST_PIX) begin
                            pix_cnt_r    <= CNT_ZERO;
                            frame_done_r <= 1'b1;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    mul_a_r     <= 8'h00;
                    mul_b_r     <= 8'h00;
                    mul_en_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blend_mul_scheduler.sv
// Randomized bench for blend_mul_scheduler: wrap and saturate instances share
// stimulus and are compared against an arithmetic reference of the blend.
module tb_blend_mul_scheduler;
    import blend_pkg::*;

    localparam int NP = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] pix_cnt0;
    logic [2:0] pix_cnt1;
    logic       frame_done0;
    logic       frame_done1;

    int checks;
    int errors;
    int mcnt;
    int fw1;
    int fw2;

    blend_mul_scheduler_if bus0();
    blend_mul_scheduler_if bus1();

    assign bus1.w1        = bus0.w1;
    assign bus1.w2        = bus0.w2;
    assign bus1.p1        = bus0.p1;
    assign bus1.p2        = bus0.p2;
    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.out_ready = bus0.out_ready;
    assign bus0.mul_y     = 16'(bus0.mul_a) * 16'(bus0.mul_b);
    assign bus1.mul_y     = 16'(bus1.mul_a) * 16'(bus1.mul_b);

    blend_mul_scheduler #(.NUM_PIXELS(NP), .SATURATE(1'b0), .CNT_W(3)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .pix_cnt(pix_cnt0), .frame_done(frame_done0)
    );

    blend_mul_scheduler #(.NUM_PIXELS(NP), .SATURATE(1'b1), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .pix_cnt(pix_cnt1), .frame_done(frame_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_blend(input int w1, input int p1, input int w2, input int p2, input bit sat);
        int s;
        s = (w1 * p1) / 256 + (w2 * p2) / 256;
        if (sat) return (s > 255) ? 255 : s;
        return s % 256;
    endfunction

    task automatic do_pixel(input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] w1, input logic [7:0] w2, input int stall);
        int guard;
        int e0;
        int e1;
        bit fd;
        guard = 0;
        while (bus0.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_wait", bus0.in_ready, 1);
        bus0.p1 = p1; bus0.p2 = p2; bus0.w1 = w1; bus0.w2 = w2;
        bus0.in_valid = 1'b1;
        if (mcnt == 0) begin
            fw1 = w1;
            fw2 = w2;
        end
        e0 = ref_blend(fw1, p1, fw2, p2, 1'b0);
        e1 = ref_blend(fw1, p1, fw2, p2, 1'b1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.p1 = 8'($urandom); bus0.p2 = 8'($urandom);
        bus0.w1 = 8'($urandom); bus0.w2 = 8'($urandom);
        check_eq("mul1_en", bus0.mul_en, 1);
        check_eq("mul1_a", bus0.mul_a, fw1);
        check_eq("mul1_b", bus0.mul_b, p1);
        check_eq("busy_in_ready", bus0.in_ready, 0);
        check_eq("frame_done_low", frame_done0, 0);
        @(negedge clk);
        check_eq("mul2_a", bus0.mul_a, fw2);
        check_eq("mul2_b", bus0.mul_b, p2);
        check_eq("early_out_valid", bus0.out_valid, 0);
        @(negedge clk);
        check_eq("out_valid", bus0.out_valid, 1);
        check_eq("out_pix_wrap", bus0.out_pix, e0);
        check_eq("out_pix_sat", bus1.out_pix, e1);
        check_eq("out_mul_en", bus0.mul_en, 0);
        for (int i = 0; i < stall; i++) begin
            bus0.in_valid = 1'b1;
            @(negedge clk);
            check_eq("stall_valid", bus0.out_valid, 1);
            check_eq("stall_pix", bus0.out_pix, e0);
            check_eq("stall_in_ready", bus0.in_ready, 0);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        fd = (mcnt == NP - 1);
        mcnt = fd ? 0 : mcnt + 1;
        check_eq("post_out_valid", bus0.out_valid, 0);
        check_eq("post_in_ready", bus0.in_ready, 1);
        check_eq("pix_cnt", pix_cnt0, mcnt);
        check_eq("frame_done", frame_done0, fd);
        check_eq("frame_done_sat", frame_done1, fd);
    endtask

    initial begin
        checks = 0; errors = 0; mcnt = 0; fw1 = 0; fw2 = 0;
        rst_n = 1'b0;
        bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
        bus0.p1 = 8'h11; bus0.p2 = 8'h22; bus0.w1 = 8'h33; bus0.w2 = 8'h44;

        // Reset with in_valid asserted
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", bus0.in_ready, 0);
        check_eq("rst_out_valid", bus0.out_valid, 0);
        check_eq("rst_mul_en", bus0.mul_en, 0);
        check_eq("rst_mul_a", bus0.mul_a, 0);
        check_eq("rst_out_pix", bus0.out_pix, 0);
        check_eq("rst_pix_cnt", pix_cnt0, 0);
        rst_n = 1'b1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check_eq("release_in_ready", bus0.in_ready, 1);

        // Half-and-half blend, then backpressure and a mid-frame weight change
        do_pixel(8'hC8, 8'h64, HALF_WEIGHT, HALF_WEIGHT, 0);
        check_eq("basic_blend", bus0.out_pix, 8'h96);
        do_pixel(8'h10, 8'hF0, 8'h20, 8'h40, 5);
        do_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
        do_pixel(8'h7F, 8'h01, 8'h01, 8'h02, 0);

        // New frame picks up full-scale weights: overflow case
        do_pixel(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        check_eq("ovf_wrap", bus0.out_pix, 8'hFC);
        check_eq("ovf_sat", bus1.out_pix, 8'hFF);

        // Reset while the second product is being formed
        bus0.p1 = 8'h55; bus0.p2 = 8'hAA; bus0.in_valid = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", bus0.out_valid, 0);
        check_eq("midrst_pix_cnt", pix_cnt0, 0);
        check_eq("midrst_mul_en", bus0.mul_en, 0);
        rst_n = 1'b1;
        mcnt = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("midrst_no_out", bus0.out_valid, 0);

        for (int k = 0; k < 24; k++) begin
            do_pixel(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
